// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg
// Shared constants and types for the two-requester adder arbiter:
//   W_DEF / CW_DEF : default operand width and grant-counter width
//   state_t        : result-slot state (EMPTY / FULL)
//   req_id_t       : requester index
package adder_arbiter_pkg;

   localparam int W_DEF  = 5;
   localparam int CW_DEF = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ0 = 1'b0;
   localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin grant. A lone valid requester always wins; when both
// are valid the priority pointer decides. The pointer moves to the loser
// after every accepted request and holds otherwise.
// Ports:
//   clk, rst_n   : clock, async active-low reset (pointer -> requester 0)
//   i_valid0/1   : requester valids
//   i_slot_free  : result slot can take a new result this cycle
//   o_grant      : requester currently selected
//   o_accept     : selected requester's operands are taken this cycle
module rr_arb2
   import adder_arbiter_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    i_valid0,
   input  logic    i_valid1,
   input  logic    i_slot_free,
   output req_id_t o_grant,
   output logic    o_accept
);

   req_id_t r_prio;
   req_id_t w_grant;
   logic    w_accept;

   always_comb begin
      w_grant = r_prio;
      if (i_valid0 && !i_valid1)
         w_grant = REQ0;
      else if (i_valid1 && !i_valid0)
         w_grant = REQ1;
      w_accept = i_slot_free && ((w_grant == REQ1) ? i_valid1 : i_valid0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_prio <= REQ0;
      else if (w_accept)
         r_prio <= ~w_grant;
   end

   assign o_grant  = w_grant;
   assign o_accept = w_accept;

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter
// Two requesters share one W-bit adder. The round-robin winner's operands
// are summed combinationally and captured in a single result register,
// visible one cycle after the accepting edge. Per-requester saturating
// counters track accepted requests.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   reqN_valid/a/b/ready       : requester N handshake and operands (N=0,1)
//   rsp_valid/sum/overflow/id  : held result, carry-out, producing requester
//   rsp_ready                  : consumer takes the result
//   grant_cnt0/1               : saturating accepted-request counts
//
// state | meaning
// EMPTY | result register holds nothing (rsp_valid=0)
// FULL  | result register holds an unconsumed result (rsp_valid=1)
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   input  logic [W-1:0]  req0_a,
   input  logic [W-1:0]  req0_b,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [W-1:0]  req1_a,
   input  logic [W-1:0]  req1_b,
   output logic          req1_ready,
   output logic          rsp_valid,
   output logic [W-1:0]  rsp_sum,
   output logic          rsp_overflow,
   output logic          rsp_id,
   input  logic          rsp_ready,
   output logic [CW-1:0] grant_cnt0,
   output logic [CW-1:0] grant_cnt1
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [W-1:0]  r_sum;
   logic          r_ovf;
   req_id_t       r_id;
   logic [CW-1:0] r_cnt0;
   logic [CW-1:0] r_cnt1;

   logic          w_slot_free;
   req_id_t       w_grant;
   logic          w_accept;
   logic [W-1:0]  w_a;
   logic [W-1:0]  w_b;
   logic [W:0]    w_sum_full;

   // rst_n gates the slot so no requester sees ready while in reset.
   assign w_slot_free = rst_n && ((r_state == EMPTY) || rsp_ready);

   rr_arb2 u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid0    (req0_valid),
      .i_valid1    (req1_valid),
      .i_slot_free (w_slot_free),
      .o_grant     (w_grant),
      .o_accept    (w_accept)
   );

   assign w_a        = (w_grant == REQ1) ? req1_a : req0_a;
   assign w_b        = (w_grant == REQ1) ? req1_b : req0_b;
   assign w_sum_full = {1'b0, w_a} + {1'b0, w_b};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY:   if (w_accept) w_state_nxt = FULL;
         FULL:    if (!w_accept && rsp_ready) w_state_nxt = EMPTY;
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= EMPTY;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= '0;
         r_ovf <= 1'b0;
         r_id  <= REQ0;
      end else if (w_accept) begin
         r_sum <= w_sum_full[W-1:0];
         r_ovf <= w_sum_full[W];
         r_id  <= w_grant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (w_accept) begin
         if (w_grant == REQ0 && r_cnt0 != '1)
            r_cnt0 <= r_cnt0 + CW'(1);
         if (w_grant == REQ1 && r_cnt1 != '1)
            r_cnt1 <= r_cnt1 + CW'(1);
      end
   end

   assign req0_ready   = w_slot_free && (w_grant == REQ0);
   assign req1_ready   = w_slot_free && (w_grant == REQ1);
   assign rsp_valid    = (r_state == FULL);
   assign rsp_sum      = r_sum;
   assign rsp_overflow = r_ovf;
   assign rsp_id       = r_id;
   assign grant_cnt0   = r_cnt0;
   assign grant_cnt1   = r_cnt1;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid, rsp_ready;
   logic [4:0] req0_a, req0_b, req1_a, req1_b;

   logic       req0_ready, req1_ready, rsp_valid, rsp_overflow, rsp_id;
   logic [4:0] rsp_sum;
   logic [7:0] grant_cnt0, grant_cnt1;

   // small-counter instance sharing the same stimulus, for saturation
   logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_overflow, s_rsp_id;
   logic [4:0] s_rsp_sum;
   logic [1:0] s_grant_cnt0, s_grant_cnt1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   adder_arbiter #(.W(5), .CW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow),
      .rsp_id(rsp_id), .rsp_ready(rsp_ready),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   adder_arbiter #(.W(5), .CW(2)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_req1_ready),
      .rsp_valid(s_rsp_valid), .rsp_sum(s_rsp_sum), .rsp_overflow(s_rsp_overflow),
      .rsp_id(s_rsp_id), .rsp_ready(rsp_ready),
      .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [4:0] s,
                            input logic o, input logic id);
      check_val({tag, ".valid"}, 32'(rsp_valid), 32'(v));
      check_val({tag, ".sum"},   32'(rsp_sum), 32'(s));
      check_val({tag, ".ovf"},   32'(rsp_overflow), 32'(o));
      check_val({tag, ".id"},    32'(rsp_id), 32'(id));
   endtask

   task automatic check_rdy(input string tag, input logic r0, input logic r1);
      check_val({tag, ".rdy0"}, 32'(req0_ready), 32'(r0));
      check_val({tag, ".rdy1"}, 32'(req1_ready), 32'(r1));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      #2;
      check_rsp("reset", 0, 0, 0, 0);
      check_rdy("reset", 0, 0);
      check_val("reset.cnt0", 32'(grant_cnt0), 0);
      check_val("reset.cnt1", 32'(grant_cnt1), 0);
      step();
      rst_n = 1'b1;

      // single requester, no overflow
      req0_valid = 1; req0_a = 3; req0_b = 4; rsp_ready = 1;
      #1;
      check_rdy("single", 1, 0);
      step();
      req0_valid = 0;
      check_rsp("single", 1, 7, 0, 0);
      check_val("single.cnt0", 32'(grant_cnt0), 1);

      // overflow from requester 1: 20+15=35 -> 3, carry
      req1_valid = 1; req1_a = 20; req1_b = 15;
      #1;
      check_rdy("ovf", 0, 1);
      step();
      req1_valid = 0;
      check_rsp("ovf", 1, 3, 1, 1);
      check_val("ovf.cnt1", 32'(grant_cnt1), 1);

      // contention from a fresh reset: ids alternate 0,1,0,1
      do_reset();
      req0_valid = 1; req0_a = 1;  req0_b = 2;
      req1_valid = 1; req1_a = 10; req1_b = 10;
      rsp_ready = 1;
      step(); check_rsp("cont0", 1, 3, 0, 0);
      step(); check_rsp("cont1", 1, 20, 0, 1);
      step(); check_rsp("cont2", 1, 3, 0, 0);
      step(); check_rsp("cont3", 1, 20, 0, 1);
      check_val("cont.cnt0", 32'(grant_cnt0), 2);
      check_val("cont.cnt1", 32'(grant_cnt1), 2);

      // backpressure: result (id1, 20) held, readies low, operand change legal
      rsp_ready = 0;
      req0_a = 7;  req0_b = 9;
      req1_a = 31; req1_b = 31;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_rdy("bp.hold", 0, 0);
         if (i == 1) req0_a = 8;
         step();
         check_rsp("bp.hold", 1, 20, 0, 1);
      end
      rsp_ready = 1;
      #1;
      check_rdy("bp.release", 1, 0);
      step();
      check_rsp("bp.consume_accept", 1, 17, 0, 0);
      req0_valid = 0;
      step();
      check_rsp("bp.next", 1, 30, 1, 1);
      req1_valid = 0;
      step();
      check_val("bp.drain", 32'(rsp_valid), 0);
      check_val("bp.cnt0", 32'(grant_cnt0), 3);
      check_val("bp.cnt1", 32'(grant_cnt1), 3);

      // reset while FULL with prio pointing at requester 1
      req0_valid = 1; req0_a = 5; req0_b = 6;
      req1_valid = 1; req1_a = 2; req1_b = 2;
      step();
      check_rsp("prerst", 1, 11, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check_rsp("async_rst", 0, 0, 0, 0);
      check_rdy("async_rst", 0, 0);
      check_val("async_rst.cnt0", 32'(grant_cnt0), 0);
      step();
      rst_n = 1'b1;
      #1;
      check_rdy("postrst", 1, 0);
      step();
      check_rsp("postrst", 1, 11, 0, 0);

      // saturation: 5 accepts from requester 0 after reset
      req1_valid = 0;
      do_reset();
      req0_a = 1; req0_b = 1;
      for (int i = 0; i < 5; i++) step();
      req0_valid = 0;
      check_val("sat.cw2_cnt0", 32'(s_grant_cnt0), 3);
      check_val("sat.cw8_cnt0", 32'(grant_cnt0), 5);
      check_val("sat.cnt1", 32'(s_grant_cnt1), 0);
      check_val("sat.sum", 32'(s_rsp_sum), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter W, default 5, operand and sum width in bits.
REQ-002 Parameter CW, default 8, width of each grant-statistics counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid  input  1  requester 0 holds an operand pair.
REQ-006 req0_a, req0_b  input  W each  requester 0 operands, unsigned.
REQ-007 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready  same as REQ-005..007 for requester 1.
REQ-009 rsp_valid  output  1  result register holds an unconsumed result.
REQ-010 rsp_sum  output  W  low W bits of a+b.
REQ-011 rsp_overflow  output  1  carry out of bit W-1 of a+b.
REQ-012 rsp_id  output  1  index of the requester that produced the result.
REQ-013 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-014 grant_cnt0, grant_cnt1  output  CW each  accepted-request counts, per requester.

Function
REQ-015 One shared combinational W-bit adder; operands selected by grant mux; result captured in a single output register.
REQ-016 Handshakes: transfer occurs when valid and ready are both high on a rising edge; valid never depends on ready.
REQ-017 Slot free = !rsp_valid or (rsp_valid and rsp_ready); reqN_ready = slot free and grant==N, combinationally.
REQ-018 Grant: only one requester valid -> it wins; both valid -> requester named by priority pointer prio wins.
REQ-019 prio toggles to the non-winner after every accepted request; unchanged when nothing is accepted.
REQ-020 Latency: result visible on rsp_* exactly one cycle after the accepting edge.
REQ-021 Throughput: one result per cycle when rsp_ready is held high.
REQ-022 State: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-023 EMPTY -> FULL on accept. FULL -> EMPTY on rsp_ready with no accept. FULL -> FULL, with new data, on simultaneous consume and accept.
REQ-024 While FULL and rsp_ready low, rsp_sum, rsp_overflow and rsp_id are held stable; both reqN_ready are low.
REQ-025 rsp_sum = (a+b) mod 2^W; rsp_overflow = ((a+b) >= 2^W).
REQ-026 grant_cntN increments on each accept from requester N and saturates at 2^CW-1; no wrap.
REQ-027 Operand changes while valid is high without ready are legal; the value sampled at the accepting edge is used.

Reset
REQ-028 rst_n low asynchronously sets rsp_valid=0, rsp_sum=0, rsp_overflow=0, rsp_id=0, prio=0, grant_cnt0=grant_cnt1=0.
REQ-029 Reset mid-transfer discards the held result; the first accept after release grants requester 0 if both are valid.
REQ-030 reqN_ready is 0 while rst_n is low.

Structure
REQ-031 Package adder_arbiter_pkg holds: default W and CW constants; state enum {EMPTY, FULL}; requester-id typedef.
REQ-032 Sub-module rr_arb2 holds the two-way round-robin grant with its prio register; the adder and output register stay in adder_arbiter.

Verification
REQ-033 Single requester: req0 a=3, b=4, rsp_ready=1 -> next cycle rsp_sum=7, rsp_overflow=0, rsp_id=0, grant_cnt0=1.
REQ-034 Overflow: req1 a=20, b=15, W=5 -> rsp_sum=3, rsp_overflow=1, rsp_id=1.
REQ-035 Contention: both requesters valid for 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1; grant_cnt0=grant_cnt1=2.
REQ-036 Backpressure: rsp_ready=0 for 3 cycles after a result -> rsp_* held stable, both ready low; on rsp_ready=1, consume and next accept happen in the same cycle.
REQ-037 Saturation: CW=2, 5 accepts from req0 -> grant_cnt0=3.
REQ-038 Reset: assert rst_n low while FULL -> rsp_valid=0 immediately, before the next clk edge; after release with both requesters valid, first grant goes to requester 0.
